// File: rtl/div_if.sv
// ---------------------------------------------------------------------------
// div_if
// Request/response bundle between the execute-stage pipeline and div_unit.
//   start       pipeline -> div  divide request (level, held while stalled)
//   signed_div  pipeline -> div  1 = DIV (signed), 0 = DIVU
//   a, b        pipeline -> div  dividend / divisor
//   cancel      pipeline -> div  execute-stage flush, aborts the operation
//   result      div -> pipeline  {remainder, quotient}, feeds HI/LO
//   ready       div -> pipeline  one-cycle HI/LO write qualifier
//   stall       div -> pipeline  hold the pipeline while busy
// ---------------------------------------------------------------------------
interface div_if;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic [63:0] result;
  logic        ready;
  logic        stall;

  modport master (
    output start, signed_div, a, b, cancel,
    input  result, ready, stall
  );

  modport slave (
    input  start, signed_div, a, b, cancel,
    output result, ready, stall
  );
endinterface

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
// Iterative 32-bit signed/unsigned restoring divider for the MIPS execute
// stage. Produces {remainder, quotient} for the HI/LO register.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-low reset
//   bus  div_if.slave: start/signed_div/a/b/cancel in; result/ready/stall out
// Latency: 33 cycles from acceptance to ready (1 cycle for divide by zero).
// ---------------------------------------------------------------------------
module div_unit (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  count;
  logic [63:0] prem;        // {partial remainder, dividend/quotient bits}
  logic [31:0] dvsr;        // divisor magnitude
  logic        neg_q;
  logic        neg_r;
  logic [63:0] result_q;

  logic        accept;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [33:0] diff;
  logic        ge;
  logic [63:0] prem_nxt;
  logic [31:0] q_fin;
  logic [31:0] r_fin;

  assign accept = (state == IDLE) && bus.start && !bus.cancel;

  // Magnitudes are taken only in signed mode; DIVU uses the raw operands.
  assign a_mag = (bus.signed_div && bus.a[31]) ? -bus.a : bus.a;
  assign b_mag = (bus.signed_div && bus.b[31]) ? -bus.b : bus.b;

  // The remainder can be up to 2^32-2, so after the shift the trial value
  // needs 33 bits (prem[63:31]); one extra bit catches the borrow.
  assign diff     = {1'b0, prem[63:31]} - {2'b00, dvsr};
  assign ge       = !diff[33];
  assign prem_nxt = ge ? {diff[31:0], prem[30:0], 1'b1}
                       : {prem[62:0], 1'b0};

  // Sign correction: quotient negative when operand signs differ,
  // remainder follows the dividend. 0x80000000 / -1 wraps naturally.
  assign q_fin = neg_q ? -prem_nxt[31:0]  : prem_nxt[31:0];
  assign r_fin = neg_r ? -prem_nxt[63:32] : prem_nxt[63:32];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: next-state gets its default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = (bus.b == '0) ? DONE : BUSY;
      BUSY:    if (count == 5'd31) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Flush wins over everything.
    if (bus.cancel) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      prem     <= '0;
      dvsr     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= '0;
    end else if (!bus.cancel) begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            count <= '0;
            prem  <= {32'h0, a_mag};
            dvsr  <= b_mag;
            neg_q <= bus.signed_div & (bus.a[31] ^ bus.b[31]);
            neg_r <= bus.signed_div & bus.a[31];
            if (bus.b == '0) result_q <= {bus.a, 32'hFFFF_FFFF};
          end
        end
        BUSY: begin
          prem  <= prem_nxt;
          count <= count + 5'd1;
          if (count == 5'd31) result_q <= {r_fin, q_fin};
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.ready  = (state == DONE);
  // Gated by rst so the pipeline is never held while the divider is in reset.
  assign bus.stall  = rst && (accept || (state == BUSY));

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit
// Scoreboard bench for div_unit: stimulus pushes expected {r,q} and the
// cycle ready is due; a monitor pops and compares on every ready pulse.
// ---------------------------------------------------------------------------
module tb_div_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_if dif();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  typedef struct {
    logic [63:0] res;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int          cycle  = 0;
  logic [63:0] last_res = '0;
  bit          prev_ready = 1'b0;

  always @(posedge clk) cycle++;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic with the MIPS conventions.
  function automatic logic [63:0] ref_div(bit sd, logic [31:0] a, logic [31:0] b);
    logic [31:0] q, r;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (!sd) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {r, q};
  endfunction

  // Monitor: every ready pulse must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (rst === 1'b1 && dif.ready === 1'b1) begin
      if (prev_ready) begin
        errors++;
        checks++;
        $display("FAIL ready_pulse: got two consecutive ready cycles (t=%0t)", $time);
      end
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_ready: got ready with result %h, expected none (t=%0t)",
                 dif.result, $time);
      end else begin
        e = sb.pop_front();
        check("result", dif.result, e.res);
        check("ready_cycle", 64'(cycle), 64'(e.due));
      end
    end
    prev_ready = (dif.ready === 1'b1);
  end

  task automatic issue(bit sd, logic [31:0] a, logic [31:0] b, output int t0);
    exp_t x;
    @(posedge clk); #1;
    dif.start      = 1'b1;
    dif.signed_div = sd;
    dif.a          = a;
    dif.b          = b;
    t0    = cycle;
    x.res = ref_div(sd, a, b);
    x.due = cycle + ((b == 0) ? 1 : 33);
    sb.push_back(x);
  endtask

  // Holds start until ready; checks stall every cycle. Leaves start high so
  // the next issue lands in the first IDLE cycle after DONE.
  task automatic run_op(bit sd, logic [31:0] a, logic [31:0] b);
    int t0;
    int lim;
    bit got;
    issue(sd, a, b, t0);
    lim = (b == 0) ? 0 : 32;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      check("stall", 64'(dif.stall), 64'((cycle - t0) <= lim));
      if (dif.ready === 1'b1) got = 1'b1;
    end
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL timeout: got no ready within 40 cycles, expected ready for a=%h b=%h", a, b);
      sb.delete();
    end else begin
      last_res = ref_div(sd, a, b);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish by 2 ms, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t0;
    logic [31:0] ra, rb;
    bit          rsd;

    // Reset state, with start high to prove stall is gated by reset.
    rst            = 1'b0;
    dif.start      = 1'b1;
    dif.signed_div = 1'b0;
    dif.a          = 32'd5;
    dif.b          = 32'd1;
    dif.cancel     = 1'b0;
    #12;
    check("rst_stall",  64'(dif.stall), 64'd0);
    check("rst_ready",  64'(dif.ready), 64'd0);
    check("rst_result", dif.result,     64'd0);
    dif.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // Directed cases.
    run_op(1'b0, 32'd100,        32'd7);
    run_op(1'b1, 32'hFFFF_FFF9,  32'd2);
    run_op(1'b1, 32'd7,          32'hFFFF_FFFE);
    run_op(1'b0, 32'h1234_5678,  32'd0);
    run_op(1'b1, 32'h8000_0000,  32'hFFFF_FFFF);
    run_op(1'b0, 32'hFFFF_FFFF,  32'd1);
    run_op(1'b1, 32'h8000_0000,  32'd0);

    // Cancel in cycle 10: no ready, result untouched, then a fresh op.
    issue(1'b0, 32'd1000, 32'd3, t0);
    repeat (10) @(posedge clk);
    #1;
    dif.cancel = 1'b1;
    dif.start  = 1'b0;
    void'(sb.pop_back());
    @(posedge clk); #1;
    dif.cancel = 1'b0;
    @(negedge clk);
    check("cancel_stall", 64'(dif.stall), 64'd0);
    check("cancel_ready", 64'(dif.ready), 64'd0);
    repeat (30) @(negedge clk);
    check("cancel_result", dif.result, last_res);
    run_op(1'b1, 32'hFFFF_FC18, 32'd7);

    // Cancel together with start in IDLE: nothing starts.
    @(posedge clk); #1;
    dif.start  = 1'b1;
    dif.cancel = 1'b1;
    dif.a      = 32'd77;
    dif.b      = 32'd0;
    @(negedge clk);
    check("start_cancel_stall", 64'(dif.stall), 64'd0);
    @(posedge clk); #1;
    dif.start  = 1'b0;
    dif.cancel = 1'b0;
    repeat (3) @(negedge clk);
    check("start_cancel_result", dif.result, last_res);

    // Reset in BUSY cycle 5: outputs drop immediately.
    issue(1'b0, 32'd50, 32'd5, t0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_result", dif.result,     64'd0);
    check("midrst_ready",  64'(dif.ready), 64'd0);
    check("midrst_stall",  64'(dif.stall), 64'd0);
    sb.delete();
    dif.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    last_res = '0;
    run_op(1'b0, 32'd9, 32'd3);

    // Randomized operations, back to back.
    for (int i = 0; i < 30; i++) begin
      rsd = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       ra = 32'h8000_0000;
        1:       ra = $urandom_range(0, 1000);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2, 3:    rb = $urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      run_op(rsd, ra, rb);
    end

    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (40) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit signed/unsigned divider for the MIPS execute stage. It produces the {remainder, quotient} pair that the HI/LO register captures: remainder goes to HI, quotient to LO. It sits directly upstream of the HI/LO register write port. It stalls the pipeline with `stall` while a division is in flight.

## Interface
- No parameters; datapath is fixed at 32 bits.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  divide request; level, held by the pipeline while stalled.
- `signed_div`  in  1  1 = DIV (signed), 0 = DIVU; sampled with `start`.
- `a`  in  32  dividend; sampled when the operation is accepted.
- `b`  in  32  divisor; sampled when the operation is accepted.
- `cancel`  in  1  abort, driven by the execute-stage flush (flushE); synchronous.
- `result`  out  64  {remainder[63:32], quotient[31:0]}; feeds hi_i/lo_i.
- `ready`  out  1  result valid; HI/LO write-enable qualifier; exactly one cycle per operation.
- `stall`  out  1  hold the pipeline (combinational).

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE**
  - If `start` && !`cancel`: latch operands, sign mode and |a|, |b| (magnitudes only in signed mode).
  - If b != 0: go to BUSY and clear the count.
  - If b == 0: go straight to DONE. Quotient = 0xFFFFFFFF, remainder = a.
- **BUSY**
  - Restoring radix-2 algorithm, one quotient bit per cycle, 64-bit partial-remainder register.
  - Each cycle: shift left by 1, subtract divisor from the upper half; if the result is non-negative, keep it and set quotient bit = 1.
  - 5-bit counter 0..31. On the iteration with count == 31, write `result` with sign correction applied, then go to DONE.
- **DONE**
  - `ready` = 1 for this one cycle. Go to IDLE unconditionally.
  - `start` is ignored in DONE. The pipeline must drop `start` after seeing `ready`.
- **Sign correction** (signed mode only):
  - Quotient is negated when a[31] ^ b[31].
  - Remainder is negated when a[31], so the remainder takes the dividend's sign.
  - Unsigned mode uses the raw magnitudes.
  - 0x80000000 / 0xFFFFFFFF (signed) yields q = 0x80000000, r = 0. This is two's-complement wrap, not an error.
- **`result`**: updated only on entry to DONE. Otherwise it holds its value, including across cancel.
- **`stall`** = (state==IDLE && `start` && !`cancel`) || state==BUSY.
  - Deasserted in DONE, so the instruction advances with `ready` = 1.
- **`cancel`**: highest priority. From any state, go to IDLE next edge.
  - `ready` must not assert for the cancelled operation. `result` is unchanged.
  - `start` together with `cancel` in IDLE: no operation is started.

## Timing
- Reset (rst = 0, asynchronous):
  - State IDLE, count 0, `result` = 0, `ready` = 0.
  - `stall` = 0 while rst is low.
- Normal latency: `start` accepted in cycle 0 → BUSY cycles 1–32 → DONE in cycle 33, with `ready` = 1 and `result` valid.
  - `stall` is high in cycles 0–32.
- Divide-by-zero latency: accepted in cycle 0 → DONE in cycle 1. `stall` is high in cycle 0 only.
- Back-to-back operations: a new `start` is accepted in the first IDLE cycle after DONE (cycle 34 at the earliest).
- Reset mid-operation: aborts immediately; no `ready` for that operation.
- `ready` is never high for more than 1 consecutive cycle.

## Test plan
- Unsigned 100 / 7, start held until `ready` → `ready` in cycle 33; result = {0x00000002, 0x0000000E}; `stall` high cycles 0–32.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002) → q = 0xFFFFFFFD, r = 0xFFFFFFFF.
  - Signed 7 / −2 → q = 0xFFFFFFFD, r = 0x00000001.
- Divide by zero: a = 0x12345678, b = 0 → `ready` in cycle 1; result = {0x12345678, 0xFFFFFFFF}.
- Signed 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}.
  - Unsigned 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF}.
- `cancel` pulsed in cycle 10 of an operation → IDLE in cycle 11; no `ready`; `result` keeps its previous value.
  - A fresh start then completes correctly in 33 cycles.
- rst asserted in cycle 5 of BUSY → all outputs 0 immediately.
  - After release, 9 / 3 unsigned → {0, 3} at cycle 33.
